// File: rtl/dft_feeder_pkg.sv
// Shared types and constants for the DFT sample feeder.
package dft_feeder_pkg;

    typedef logic signed [15:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        WAIT
    } feeder_state_t;

    localparam int unsigned DFT_SAMPLE_GAP = 250;

endpackage

// File: rtl/sample_fifo.sv
// Single-clock sample FIFO with a registered occupancy count.
module sample_fifo #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             pushData,
    input  logic                     pop,
    output logic [W-1:0]             popData,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_pop  = pop && !empty;
    // A pop frees the head slot at the same edge, so a push into a full FIFO still fits.
    assign do_push = push && (!full || do_pop);
    assign popData = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= pushData;
        end
    end

endmodule

// File: rtl/dft_sample_feeder.sv
// Buffers front-end samples and releases them to the DFT as one-cycle pulses
// separated by at least GAP idle cycles.
module dft_sample_feeder
    import dft_feeder_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned GAP   = DFT_SAMPLE_GAP
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [W-1:0]    inSample,
    input  logic                   inValid,
    output logic signed [W-1:0]    inputSample,
    output logic                   sampleReady,
    output logic [$clog2(DEPTH):0] fifoLevel,
    output logic                   overflow,
    input  logic                   clearOverflow
);
    localparam int unsigned CntW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CntW-1:0] GapLoad = (GAP > 0) ? CntW'(GAP - 1) : '0;

    feeder_state_t      state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic signed [W-1:0] sample_q, sample_d;
    logic               ovf_q, ovf_d;
    logic               pop;
    logic [W-1:0]       pop_data;
    logic               fifo_full;
    logic               fifo_empty;

    sample_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (inValid),
        .pushData (inSample),
        .pop      (pop),
        .popData  (pop_data),
        .level    (fifoLevel),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sample_d = sample_q;
        pop      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    sample_d = $signed(pop_data);
                    state_d  = EMIT;
                end
            end
            EMIT: begin
                cnt_d = GapLoad;
                // With no gap, return through IDLE so every pulse stays one cycle wide.
                if (GAP > 0) begin
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (clearOverflow) begin
            ovf_d = 1'b0;
        end
        if (inValid && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sample_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            ovf_q    <= ovf_d;
        end
    end

    assign inputSample = sample_q;
    assign sampleReady = (state_q == EMIT);
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_dft_sample_feeder.sv
// Self-checking bench: directed GAP=250 sequences, a GAP=0 vector table and a
// randomized run against a queue-based timing model.
module tb_dft_sample_feeder;

    localparam int unsigned C_DEPTH = 8;
    localparam int unsigned C_GAP   = 5;

    logic        clk;
    logic        rst;

    logic [15:0] a_in, a_out;
    logic        a_vld, a_clr, a_rdy, a_ovf;
    logic [2:0]  a_lvl;

    logic [15:0] b_in, b_out;
    logic        b_vld, b_clr, b_rdy, b_ovf;
    logic [2:0]  b_lvl;

    logic [15:0] c_in, c_out;
    logic        c_vld, c_clr, c_rdy, c_ovf;
    logic [3:0]  c_lvl;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;

    int          pc[$];
    logic [15:0] pv[$];

    typedef struct {
        logic        vld;
        logic [15:0] din;
        logic        clr;
        logic        rdy;
        logic [15:0] dout;
        int          lvl;
        logic        ovf;
    } vec_t;

    vec_t tbl[23];

    dft_sample_feeder #(.W(16), .DEPTH(4), .GAP(250)) u_dut_a (
        .clk           (clk),
        .rst           (rst),
        .inSample      (a_in),
        .inValid       (a_vld),
        .inputSample   (a_out),
        .sampleReady   (a_rdy),
        .fifoLevel     (a_lvl),
        .overflow      (a_ovf),
        .clearOverflow (a_clr)
    );

    dft_sample_feeder #(.W(16), .DEPTH(4), .GAP(0)) u_dut_b (
        .clk           (clk),
        .rst           (rst),
        .inSample      (b_in),
        .inValid       (b_vld),
        .inputSample   (b_out),
        .sampleReady   (b_rdy),
        .fifoLevel     (b_lvl),
        .overflow      (b_ovf),
        .clearOverflow (b_clr)
    );

    dft_sample_feeder #(.W(16), .DEPTH(C_DEPTH), .GAP(C_GAP)) u_dut_c (
        .clk           (clk),
        .rst           (rst),
        .inSample      (c_in),
        .inValid       (c_vld),
        .inputSample   (c_out),
        .sampleReady   (c_rdy),
        .fifoLevel     (c_lvl),
        .overflow      (c_ovf),
        .clearOverflow (c_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Outputs are sampled 1 time unit after the edge; A's pulses are logged here.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (a_rdy === 1'b1) begin
            pc.push_back(cyc);
            pv.push_back(a_out);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_log();
        pc.delete();
        pv.delete();
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        a_vld = 1'b0; a_clr = 1'b0; a_in = '0;
        b_vld = 1'b0; b_clr = 1'b0; b_in = '0;
        c_vld = 1'b0; c_clr = 1'b0; c_in = '0;
        tick();
        tick();
        chk("rst_a_rdy", a_rdy, 0); chk("rst_a_out", a_out, 0);
        chk("rst_a_lvl", a_lvl, 0); chk("rst_a_ovf", a_ovf, 0);
        chk("rst_b_rdy", b_rdy, 0); chk("rst_b_out", b_out, 0);
        chk("rst_b_lvl", b_lvl, 0); chk("rst_b_ovf", b_ovf, 0);
        chk("rst_c_rdy", c_rdy, 0); chk("rst_c_out", c_out, 0);
        chk("rst_c_lvl", c_lvl, 0); chk("rst_c_ovf", c_ovf, 0);
        rst = 1'b1;
        clear_log();
    endtask

    task automatic push_a(input logic [15:0] first, input int n);
        for (int k = 0; k < n; k++) begin
            a_vld = 1'b1;
            a_in  = first + 16'(k);
            tick();
        end
        a_vld = 1'b0;
    endtask

    task automatic fill_table();
        tbl[0]  = '{1'b1, 16'hA5A5, 1'b0, 1'b0, 16'h0000, 1, 1'b0};
        tbl[1]  = '{1'b1, 16'h0042, 1'b0, 1'b1, 16'hA5A5, 1, 1'b0};
        tbl[2]  = '{1'b1, 16'h8001, 1'b0, 1'b0, 16'hA5A5, 2, 1'b0};
        tbl[3]  = '{1'b1, 16'h7FFF, 1'b0, 1'b1, 16'h0042, 2, 1'b0};
        tbl[4]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0042, 2, 1'b0};
        tbl[5]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h8001, 1, 1'b0};
        tbl[6]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h8001, 1, 1'b0};
        tbl[7]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h7FFF, 0, 1'b0};
        tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h7FFF, 0, 1'b0};
        tbl[9]  = '{1'b1, 16'h1001, 1'b0, 1'b0, 16'h7FFF, 1, 1'b0};
        tbl[10] = '{1'b1, 16'h1002, 1'b0, 1'b1, 16'h1001, 1, 1'b0};
        tbl[11] = '{1'b1, 16'h1003, 1'b0, 1'b0, 16'h1001, 2, 1'b0};
        tbl[12] = '{1'b1, 16'h1004, 1'b0, 1'b1, 16'h1002, 2, 1'b0};
        tbl[13] = '{1'b1, 16'h1005, 1'b0, 1'b0, 16'h1002, 3, 1'b0};
        tbl[14] = '{1'b1, 16'h1006, 1'b0, 1'b1, 16'h1003, 3, 1'b0};
        tbl[15] = '{1'b1, 16'h1007, 1'b0, 1'b0, 16'h1003, 4, 1'b0};
        tbl[16] = '{1'b1, 16'h1008, 1'b0, 1'b1, 16'h1004, 4, 1'b0};
        tbl[17] = '{1'b1, 16'h1009, 1'b0, 1'b0, 16'h1004, 4, 1'b1};
        tbl[18] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h1005, 3, 1'b0};
        tbl[19] = '{1'b1, 16'h2001, 1'b0, 1'b0, 16'h1005, 4, 1'b0};
        tbl[20] = '{1'b1, 16'h2002, 1'b0, 1'b1, 16'h1006, 4, 1'b0};
        tbl[21] = '{1'b1, 16'h2003, 1'b1, 1'b0, 16'h1006, 4, 1'b1};
        tbl[22] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h1007, 3, 1'b1};
    endtask

    initial begin
        int          e0;
        int          next_allowed;
        int          e;
        bit          m_pop;
        bit          m_drop;
        logic [15:0] m_out;
        logic        m_ovf;
        logic [15:0] mq[$];
        int          rates[4] = '{15, 45, 85, 100};

        // Single sample: push edge -> pulse on the following edge, value held.
        do_reset();
        push_a(16'h1234, 1);
        chk("t1_lvl_push", a_lvl, 1);
        chk("t1_rdy_early", a_rdy, 0);
        tick();
        chk("t1_rdy", a_rdy, 1);
        chk("t1_val", a_out, 16'h1234);
        chk("t1_lvl_pop", a_lvl, 0);
        tick();
        chk("t1_rdy_off", a_rdy, 0);
        chk("t1_hold", a_out, 16'h1234);
        clear_log();
        run(300);
        chk("t1_no_extra", pc.size(), 0);
        chk("t1_hold_late", a_out, 16'h1234);

        // Burst pacing: three pulses 252 cycles apart.
        do_reset();
        push_a(16'h0001, 3);
        e0 = cyc - 2;
        run(600);
        chk("t2_count", pc.size(), 3);
        if (pc.size() == 3) begin
            chk("t2_first_latency", pc[0] - e0, 1);
            chk("t2_spacing1", pc[1] - pc[0], 252);
            chk("t2_spacing2", pc[2] - pc[1], 252);
            for (int i = 0; i < 3; i++) chk("t2_val", pv[i], i + 1);
        end
        chk("t2_ovf", a_ovf, 0);

        // Overflow with DEPTH=4: sixth sample dropped.
        do_reset();
        push_a(16'h0001, 6);
        chk("t3_ovf_set", a_ovf, 1);
        chk("t3_lvl_full", a_lvl, 4);
        run(1100);
        chk("t3_count", pv.size(), 5);
        for (int i = 0; i < pv.size() && i < 5; i++) chk("t3_val", pv[i], i + 1);
        chk("t3_ovf_sticky", a_ovf, 1);
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        chk("t3_ovf_clear", a_ovf, 0);

        // Full FIFO accepts a push on the pop edge.
        do_reset();
        push_a(16'h0001, 5);
        e0 = cyc - 4;
        while (cyc < e0 + 252) tick();
        chk("t4_lvl_before", a_lvl, 4);
        chk("t4_rdy_before", a_rdy, 0);
        a_vld = 1'b1;
        a_in  = 16'h0006;
        tick();
        a_vld = 1'b0;
        chk("t4_rdy_pop", a_rdy, 1);
        chk("t4_val_pop", a_out, 16'h0002);
        chk("t4_lvl_kept", a_lvl, 4);
        chk("t4_ovf_clear", a_ovf, 0);
        run(1300);
        chk("t4_count", pv.size(), 6);
        for (int i = 0; i < pv.size() && i < 6; i++) chk("t4_val", pv[i], i + 1);

        // Reset mid-WAIT with samples queued.
        do_reset();
        push_a(16'h0011, 4);
        run(7);
        chk("t5_lvl_queued", a_lvl, 3);
        rst = 1'b0;
        tick();
        chk("t5_lvl", a_lvl, 0);
        chk("t5_out", a_out, 0);
        chk("t5_rdy", a_rdy, 0);
        chk("t5_ovf", a_ovf, 0);
        rst = 1'b1;
        clear_log();
        run(400);
        chk("t5_no_pulse", pc.size(), 0);

        // GAP=0 vector table on instance B.
        do_reset();
        fill_table();
        for (int i = 0; i < 23; i++) begin
            b_vld = tbl[i].vld;
            b_in  = tbl[i].din;
            b_clr = tbl[i].clr;
            tick();
            chk($sformatf("t6_rdy[%0d]", i), b_rdy, tbl[i].rdy);
            chk($sformatf("t6_out[%0d]", i), b_out, tbl[i].dout);
            chk($sformatf("t6_lvl[%0d]", i), b_lvl, tbl[i].lvl);
            chk($sformatf("t6_ovf[%0d]", i), b_ovf, tbl[i].ovf);
        end
        b_vld = 1'b0;
        b_clr = 1'b0;

        // Randomized run on instance C against a pop-time model.
        do_reset();
        next_allowed = 0;
        m_out = '0;
        m_ovf = 1'b0;
        mq.delete();
        for (int k = 0; k < 4000; k++) begin
            c_vld = ($urandom_range(99) < rates[(k / 500) % 4]);
            c_in  = 16'($urandom);
            c_clr = ($urandom_range(31) == 0);
            e = cyc + 1;
            m_pop = (mq.size() > 0) && (e >= next_allowed);
            if (m_pop) begin
                m_out = mq.pop_front();
                next_allowed = e + C_GAP + 2;
            end
            m_drop = 1'b0;
            if (c_vld) begin
                if (mq.size() < C_DEPTH) mq.push_back(c_in);
                else m_drop = 1'b1;
            end
            if (m_drop) m_ovf = 1'b1;
            else if (c_clr) m_ovf = 1'b0;
            tick();
            checks++;
            if (c_rdy !== m_pop || c_out !== m_out || c_lvl !== 4'(mq.size()) ||
                c_ovf !== m_ovf) begin
                failures++;
                $display("FAIL rand[%0d]: got rdy=%0b out=%0h lvl=%0d ovf=%0b expected rdy=%0b out=%0h lvl=%0d ovf=%0b",
                         k, c_rdy, c_out, c_lvl, c_ovf, m_pop, m_out, mq.size(), m_ovf);
            end
        end
        c_vld = 1'b0;
        c_clr = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
